uart_rx: RTL and testbench

- Standalone 8N1 UART receiver: deserialises the serial line `rx_in` into a parallel byte on `bus_out`.
- Lets loopback benches and the top level check transmitted frames independently of the combined UART block.
- Samples each bit at its midpoint using a per-bit clock counter; rejects glitches on the start bit; flags framing errors.
- Default timing: 100 MHz clock, 115200 baud, 868 clocks per bit (8680 ns bit period).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Used by the receiver and the transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an idle-high serial line.
// Resets to 1 so a reset never fakes a start edge.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling,
// start-bit glitch rejection and framing-error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] bus_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DATA_BITS - 1);

  rx_state_e            state;
  logic [CW-1:0]        clk_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_s;
  logic                 rx_s_d;
  logic                 fall;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign fall = rx_s_d & ~rx_s;

  // Delayed copy of the synchronised line for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s_d <= 1'b1;
    end else begin
      rx_s_d <= rx_s;
    end
  end

  // Frame FSM: start qualify, data shift, stop check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      bus_out    <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (fall) begin
            state   <= START;
            clk_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            if (rx_s) begin
              bus_out    <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// Frames are built bit by bit; expectations come from frame rules.
module tb_uart_rx;

  localparam int CPB  = 64;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] bus_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int busy_rise = 0;
  logic busy_q = 1'b0;
  int dv_times[$];
  logic [7:0] dv_bytes[$];

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .bus_out    (bus_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_times.push_back(cyc);
      dv_bytes.push_back(bus_out);
    end
    if (frame_err) fe_cnt++;
    if (data_valid && frame_err) both_cnt++;
    if (busy && !busy_q) busy_rise++;
    busy_q = busy;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic bit_period(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            output int t_edge);
    t_edge = cyc;
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    bit_period(stop);
  endtask

  int         dv0, fe0, br0, te, te2, lat;
  logic [7:0] exp_bus;
  logic [7:0] d;
  logic       stop;

  initial begin
    exp_bus = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bus", 32'(bus_out), 32'h0);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (5) bit_period(1'b1);

    // Good frame 0x55 and its latency.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, te);
    repeat (4) @(negedge clk);
    exp_bus = 8'h55;
    check("f55_dv", 32'(dv_cnt - dv0), 32'd1);
    check("f55_fe", 32'(fe_cnt - fe0), 32'd0);
    check("f55_bus", 32'(bus_out), 32'(exp_bus));
    if (dv_cnt > dv0) begin
      check("f55_byte", 32'(dv_bytes[dv0]), 32'h55);
      lat = dv_times[dv0] - te;
      check("f55_lat", 32'(lat >= LAT - 2 && lat <= LAT + 2),
            32'd1);
    end

    // Short glitch on the start bit.
    dv0 = dv_cnt; fe0 = fe_cnt; br0 = busy_rise;
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (HALF + 8) @(negedge clk);
    check("gl_busy_rose", 32'(busy_rise - br0), 32'd1);
    check("gl_busy_now", 32'(busy), 32'd0);
    check("gl_dv", 32'(dv_cnt - dv0), 32'd0);
    check("gl_fe", 32'(fe_cnt - fe0), 32'd0);
    check("gl_bus", 32'(bus_out), 32'(exp_bus));
    bit_period(1'b1);

    // Bad stop bit.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, te);
    repeat (4) @(negedge clk);
    check("bad_fe", 32'(fe_cnt - fe0), 32'd1);
    check("bad_dv", 32'(dv_cnt - dv0), 32'd0);
    check("bad_bus", 32'(bus_out), 32'h55);
    bit_period(1'b1);

    // Back-to-back frames with no idle gap.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, te);
    send_frame(8'h3C, 1'b1, te2);
    repeat (4) @(negedge clk);
    exp_bus = 8'h3C;
    check("b2b_dv", 32'(dv_cnt - dv0), 32'd2);
    check("b2b_fe", 32'(fe_cnt - fe0), 32'd0);
    check("b2b_bus", 32'(bus_out), 32'(exp_bus));
    if (dv_cnt >= dv0 + 2) begin
      check("b2b_byte0", 32'(dv_bytes[dv0]), 32'hA5);
      check("b2b_byte1", 32'(dv_bytes[dv0 + 1]), 32'h3C);
      check("b2b_gap",
            32'(dv_times[dv0 + 1] - dv_times[dv0]),
            32'(10 * CPB));
    end

    // Reset during data bit 4 of 0xFF, then 0x0F.
    dv0 = dv_cnt; fe0 = fe_cnt;
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'b1);
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mr_bus", 32'(bus_out), 32'h0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_dv", 32'(data_valid), 32'd0);
    check("mr_fe", 32'(frame_err), 32'd0);
    rst = 1'b0;
    exp_bus = 8'h00;
    repeat (2) bit_period(1'b1);
    send_frame(8'h0F, 1'b1, te);
    repeat (4) @(negedge clk);
    exp_bus = 8'h0F;
    check("mr_dv_total", 32'(dv_cnt - dv0), 32'd1);
    check("mr_fe_total", 32'(fe_cnt - fe0), 32'd0);
    check("mr_bus_after", 32'(bus_out), 32'(exp_bus));

    // Break: line low for 20 bit periods.
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx_in = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check("brk_fe", 32'(fe_cnt - fe0), 32'd1);
    check("brk_dv", 32'(dv_cnt - dv0), 32'd0);
    check("brk_bus", 32'(bus_out), 32'(exp_bus));
    repeat (2) bit_period(1'b1);
    send_frame(8'h81, 1'b1, te);
    repeat (4) @(negedge clk);
    exp_bus = 8'h81;
    check("brk_dv_after", 32'(dv_cnt - dv0), 32'd1);
    check("brk_fe_after", 32'(fe_cnt - fe0), 32'd1);
    check("brk_bus_after", 32'(bus_out), 32'(exp_bus));

    // Random frames, some with a bad stop bit.
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 2)) bit_period(1'b1);
      dv0 = dv_cnt; fe0 = fe_cnt;
      send_frame(d, stop, te);
      repeat (4) @(negedge clk);
      if (stop) exp_bus = d;
      check("rnd_dv", 32'(dv_cnt - dv0), 32'(stop));
      check("rnd_fe", 32'(fe_cnt - fe0), 32'(!stop));
      check("rnd_bus", 32'(bus_out), 32'(exp_bus));
      if (!stop) bit_period(1'b1);
    end

    check("dv_fe_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
